instruction_ram_loader: RTL

//  Parametrised instruction RAM with a built-in streaming loader. A

---
 rtl/instruction_ram_loader_if.sv | 39 +++
 rtl/instruction_ram_loader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instruction_ram_loader_if.sv
// Bus bundle for instruction_ram_loader: program-load stream plus fetch port.
// The RAM takes the slave view; whoever drives loads and fetches takes master.
interface instruction_ram_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  // Load stream
  logic                  load_start;
  logic [ADDR_WIDTH-1:0] load_base;
  logic [ADDR_WIDTH:0]   load_count;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_valid;
  logic                  load_ready;
  logic                  load_busy;
  logic                  load_done;
  logic                  load_error;

  // Fetch port
  logic                  read_enable;
  logic [ADDR_WIDTH-1:0] read_address;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic                  read_out_of_range;
  logic                  parity_error;

  modport slave (
    input  load_start, load_base, load_count, load_data, load_valid,
    input  read_enable, read_address,
    output load_ready, load_busy, load_done, load_error,
    output read_data, read_valid, read_out_of_range, parity_error
  );

  modport master (
    output load_start, load_base, load_count, load_data, load_valid,
    output read_enable, read_address,
    input  load_ready, load_busy, load_done, load_error,
    input  read_data, read_valid, read_out_of_range, parity_error
  );
endinterface

// File: rtl/instruction_ram_loader.sv
// Instruction RAM with a streaming valid/ready loader and a registered fetch port.
// Optional feature macro: I_RAM_PARITY_EN -- stores an even-parity bit per word
// and flags parity_error on fetch; without it parity_error is tied low.
module instruction_ram_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 1501
) (
  input logic                     clock_i,
  input logic                     reset_n_i,
  instruction_ram_loader_if.slave bus_io
);

  // Index width actually needed by the array; upper address bits only matter
  // for the range checks.
  localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_PTR = (ADDR_WIDTH+1)'(DEPTH);

`ifdef I_RAM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [ADDR_WIDTH:0] wr_ptr_q;     // one bit wider than the address so it never wraps
  logic [ADDR_WIDTH:0] remaining_q;
  logic                load_ready_q;
  logic                load_busy_q;
  logic                load_done_q;
  logic                load_error_q;

  logic [MEM_W-1:0]      mem_q [DEPTH];
  logic [MEM_W-1:0]      mem_rd_q;    // raw array read, no reset so it maps onto block RAM
  logic                  data_ok_q;   // last fetch was in range, so mem_rd_q is what read_data shows
  logic                  read_valid_q;
  logic                  read_oor_q;

  logic                  wr_in_range;
  logic                  wr_en;
  logic [MEM_W-1:0]      wr_word;
  logic                  rd_in_range;

  assign wr_in_range = (wr_ptr_q < DEPTH_PTR);
  assign wr_en       = (state_q == ST_LOAD) && bus_io.load_valid && wr_in_range;
  assign rd_in_range = ({1'b0, bus_io.read_address} < DEPTH_PTR);

`ifdef I_RAM_PARITY_EN
  // Even parity: the stored word including its parity bit XORs to zero.
  assign wr_word = {^bus_io.load_data, bus_io.load_data};
`else
  assign wr_word = bus_io.load_data;
`endif

  // Loader FSM: captures the region on start, counts beats down, flags overrun.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      remaining_q  <= '0;
      load_ready_q <= 1'b0;
      load_busy_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          load_done_q <= 1'b0;
          if (bus_io.load_start) begin
            wr_ptr_q     <= {1'b0, bus_io.load_base};
            remaining_q  <= bus_io.load_count;
            load_error_q <= 1'b0;
            load_busy_q  <= 1'b1;
            if (bus_io.load_count == '0) begin
              // Empty load: straight to the completion pulse, no beats taken.
              state_q      <= ST_DONE;
              load_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
            end else begin
              state_q      <= ST_LOAD;
              load_ready_q <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (bus_io.load_valid) begin
            if (!wr_in_range) begin
              // Beat past the end of the array: consumed but dropped, load ends.
              load_error_q <= 1'b1;
              state_q      <= ST_DONE;
              load_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
            end else begin
              wr_ptr_q    <= wr_ptr_q + 1'b1;
              remaining_q <= remaining_q - 1'b1;
              if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
                state_q      <= ST_DONE;
                load_ready_q <= 1'b0;
                load_done_q  <= 1'b1;
              end
            end
          end
        end

        ST_DONE: begin
          state_q     <= ST_IDLE;
          load_done_q <= 1'b0;
          load_busy_q <= 1'b0;
        end

        default: begin
          state_q      <= ST_IDLE;
          load_ready_q <= 1'b0;
          load_busy_q  <= 1'b0;
          load_done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Array write and fetch read; non-blocking update gives read-before-write on collision.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_word;
    end
    if (bus_io.read_enable && rd_in_range) begin
      mem_rd_q <= mem_q[bus_io.read_address[IDX_W-1:0]];
    end
  end

  // Fetch control flags: valid one cycle after the request, range result alongside.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      read_valid_q <= 1'b0;
      read_oor_q   <= 1'b0;
      data_ok_q    <= 1'b0;
    end else begin
      read_valid_q <= bus_io.read_enable;
      if (bus_io.read_enable) begin
        read_oor_q <= !rd_in_range;
        data_ok_q  <= rd_in_range;
      end else begin
        // data_ok_q holds so read_data keeps its last value between fetches
        read_oor_q <= 1'b0;
      end
    end
  end

  assign bus_io.load_ready        = load_ready_q;
  assign bus_io.load_busy         = load_busy_q;
  assign bus_io.load_done         = load_done_q;
  assign bus_io.load_error        = load_error_q;
  assign bus_io.read_valid        = read_valid_q;
  assign bus_io.read_out_of_range = read_oor_q;
  assign bus_io.read_data         = data_ok_q ? mem_rd_q[DATA_WIDTH-1:0] : '0;

`ifdef I_RAM_PARITY_EN
  // Parity is checked on the registered word, so the flag lines up with read_valid.
  assign bus_io.parity_error = read_valid_q & data_ok_q & (^mem_rd_q);
`else
  assign bus_io.parity_error = 1'b0;
`endif

endmodule
